// File: rtl/cora_aer_pkg.sv
// Shared AER bus definitions: default field widths, bit positions and the event packer.
// Imported by the channel arbiter and by button_state.
package cora_aer_pkg;

   localparam int AER_NUM_CH = 16;
   localparam int AER_CH_W   = 4;
   localparam int AER_TS_W   = 16;
   localparam int AER_CNT_W  = 12;
   localparam int AER_W      = AER_CH_W + AER_TS_W;

   localparam int AER_TS_LSB = 0;
   localparam int AER_TS_MSB = AER_TS_W - 1;
   localparam int AER_CH_LSB = AER_TS_W;
   localparam int AER_CH_MSB = AER_W - 1;

   function automatic logic [AER_W-1:0] aer_pack(input logic [AER_CH_W-1:0] ch,
                                                 input logic [AER_TS_W-1:0] ts);
      return {ch, ts};
   endfunction

endpackage

// File: rtl/aer_channel_arbiter_if.sv
// AER output bus between the channel arbiter (master) and its consumer (slave).
interface aer_channel_arbiter_if
   import cora_aer_pkg::*;
#(
   parameter int CH_W = AER_CH_W,
   parameter int TS_W = AER_TS_W
) ();

   logic                 aer_valid;
   logic                 aer_ready;
   logic [CH_W+TS_W-1:0] aer_data;
   logic [CH_W-1:0]      channel_id;

   modport master (output aer_valid, output aer_data, output channel_id, input aer_ready);
   modport slave  (input aer_valid, input aer_data, input channel_id, output aer_ready);

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_priority_pick
   import cora_aer_pkg::*;
#(
   parameter int NUM_CH = AER_NUM_CH,
   parameter int IDX_W  = AER_CH_W
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              any_o
);

   logic [IDX_W-1:0] k;

   // Scan from the farthest offset down so the nearest hit overwrites earlier ones.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      k     = '0;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         k = IDX_W'((int'(ptr_i) + off) % NUM_CH);
         if (req_i[k]) begin
            gnt_o    = '0;
            gnt_o[k] = 1'b1;
            idx_o    = k;
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aer_channel_arbiter.sv
// Merges per-channel spike requests onto one AER bus, stamping each event with the
// window-relative timestamp; holds the timestamp, rr pointer, output register and event count.
module aer_channel_arbiter
   import cora_aer_pkg::*;
#(
   parameter int NUM_CH = AER_NUM_CH,
   parameter int CH_W   = AER_CH_W,
   parameter int TS_W   = AER_TS_W,
   parameter int CNT_W  = AER_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 clear_window,
   input  logic [NUM_CH-1:0]    req,
   output logic [NUM_CH-1:0]    grant,
   aer_channel_arbiter_if.master aer,
   output logic [CNT_W-1:0]     event_count,
   output logic                 ts_overflow
);

   logic [TS_W-1:0]      ts_q, ts_d;
   logic                 ovf_q, ovf_d;
   logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                 valid_q, valid_d;
   logic [CH_W+TS_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [NUM_CH-1:0]    pick_gnt;
   logic [CH_W-1:0]      pick_idx;
   logic                 pick_any;
   logic                 slot_free, do_grant, handshake;
   logic [CH_W+TS_W-1:0] evt_w;

   rr_priority_pick #(.NUM_CH(NUM_CH), .IDX_W(CH_W)) u_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   if (CH_W == AER_CH_W && TS_W == AER_TS_W) begin : g_pack
      assign evt_w = aer_pack(pick_idx, ts_q);
   end else begin : g_cat
      assign evt_w = {pick_idx, ts_q};
   end

   assign slot_free = !valid_q || aer.aer_ready;
   assign handshake = valid_q && aer.aer_ready;
   assign do_grant  = enable && slot_free && !clear_window && pick_any;
   assign grant     = do_grant ? pick_gnt : '0;

   // clear_window overrides grants, drains and counting in the same cycle.
   always_comb begin
      ts_d     = ts_q;
      ovf_d    = ovf_q;
      rr_ptr_d = rr_ptr_q;
      valid_d  = valid_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      if (clear_window) begin
         ts_d    = '0;
         ovf_d   = 1'b0;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else begin
         if (enable && ts_q != '1) ts_d = ts_q + 1'b1;
         ovf_d = ovf_q || (&ts_d);
         if (handshake) begin
            valid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end
         if (do_grant) begin
            valid_d  = 1'b1;
            data_d   = evt_w;
            rr_ptr_d = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q     <= '0;
         ovf_q    <= 1'b0;
         rr_ptr_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
      end else begin
         ts_q     <= ts_d;
         ovf_q    <= ovf_d;
         rr_ptr_q <= rr_ptr_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
      end
   end

   assign aer.aer_valid  = valid_q;
   assign aer.aer_data   = data_q;
   assign aer.channel_id = data_q[TS_W +: CH_W];
   assign event_count    = cnt_q;
   assign ts_overflow    = ovf_q;

endmodule

// File: tb/tb_aer_channel_arbiter.sv
// Randomized bench for aer_channel_arbiter: per-cycle behavioural model plus an event scoreboard,
// and a narrow-timestamp instance for saturation behaviour.
module tb_aer_channel_arbiter;

   localparam int NCH = 16;
   localparam int TS_MAX = 65535;
   localparam int CNT_MAX = 4095;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        enable = 1'b0, clear_window = 1'b0;
   logic [15:0] req = '0, grant;
   logic [11:0] event_count;
   logic        ts_overflow;

   logic        en4 = 1'b0, clr4 = 1'b0;
   logic [15:0] req4 = '0, grant4;
   logic [11:0] cnt4;
   logic        ovf4;

   aer_channel_arbiter_if #(.CH_W(4), .TS_W(16)) bus ();
   aer_channel_arbiter_if #(.CH_W(4), .TS_W(4))  bus4 ();

   aer_channel_arbiter #(.NUM_CH(16), .CH_W(4), .TS_W(16), .CNT_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear_window(clear_window),
      .req(req), .grant(grant), .aer(bus), .event_count(event_count), .ts_overflow(ts_overflow));

   aer_channel_arbiter #(.NUM_CH(16), .CH_W(4), .TS_W(4), .CNT_W(12)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(en4), .clear_window(clr4),
      .req(req4), .grant(grant4), .aer(bus4), .event_count(cnt4), .ts_overflow(ovf4));

   int n_chk = 0, n_fail = 0;

   // Reference state: timestamp, pointer, count as plain integers; pending events in a queue.
   int          m_ts, m_ptr, m_cnt;
   bit          m_valid, m_ovf;
   logic [15:0] req_r;
   logic [19:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ts = 0; m_ptr = 0; m_cnt = 0; m_valid = 0; m_ovf = 0;
      req_r = '0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      enable = 1'b0; clear_window = 1'b0; req = '0; bus.aer_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_grant", 64'(grant), 64'h0);
      check("rst_aer_valid", 64'(bus.aer_valid), 64'h0);
      check("rst_aer_data", 64'(bus.aer_data), 64'h0);
      check("rst_channel_id", 64'(bus.channel_id), 64'h0);
      check("rst_event_count", 64'(event_count), 64'h0);
      check("rst_ts_overflow", 64'(ts_overflow), 64'h0);
      model_reset();
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic step(input bit en, input bit clr, input bit rdy, input logic [15:0] add);
      int idx;
      logic [15:0] eg;
      @(negedge clk);
      enable = en; clear_window = clr; bus.aer_ready = rdy;
      req_r = req_r | add;
      req = req_r;
      #2;
      idx = -1;
      if (en && (!m_valid || rdy) && !clr && req_r != 0) begin
         for (int off = 0; off < NCH; off++) begin
            int k;
            k = (m_ptr + off) % NCH;
            if (req_r[k] && idx < 0) idx = k;
         end
      end
      eg = (idx >= 0) ? (16'h1 << idx) : 16'h0;
      check("grant", 64'(grant), 64'(eg));
      check("aer_valid", 64'(bus.aer_valid), 64'(m_valid));
      check("event_count", 64'(event_count), 64'(m_cnt));
      check("ts_overflow", 64'(ts_overflow), 64'(m_ovf));
      if (clr) begin
         if (m_valid && !rdy) void'(exp_q.pop_front());
         m_valid = 0; m_cnt = 0; m_ts = 0; m_ovf = 0;
      end else begin
         if (m_valid && rdy) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_valid = 0;
         end
         if (idx >= 0) begin
            exp_q.push_back({4'(idx), 16'(m_ts)});
            m_valid = 1;
            m_ptr = (idx + 1) % NCH;
            req_r[idx] = 1'b0;
         end
         if (en && m_ts < TS_MAX) begin
            m_ts++;
            if (m_ts == TS_MAX) m_ovf = 1;
         end
      end
   endtask

   task automatic rand_step();
      logic [15:0] add;
      add = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7, add);
   endtask

   // Scoreboard monitor: every accepted event must match the oldest expected one.
   initial begin : monitor
      logic [19:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n === 1'b1 && bus.aer_valid === 1'b1 && bus.aer_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_event: got %0h expected none at %0t", bus.aer_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("aer_data", 64'(bus.aer_data), 64'(e));
               check("channel_id", 64'(bus.channel_id), 64'(e[19:16]));
            end
         end
      end
   end

   initial begin
      bus.aer_ready  = 1'b0;
      bus4.aer_ready = 1'b1;
      model_reset();
      do_reset();
      en4 = 1'b1;

      // idle window start, then one request stamped at ts=5
      repeat (5) step(1, 0, 1, 16'h0);
      step(1, 0, 1, 16'h0008);
      step(1, 0, 1, 16'h0);
      check("t2_aer_data", 64'(bus.aer_data), 64'h30005);
      step(1, 0, 1, 16'h0);
      check("t2_event_count", 64'(event_count), 64'd1);

      // narrow timestamp saturates and is cleared by clear_window
      repeat (14) step(0, 0, 1, 16'h0);
      check("t6_ts_overflow_set", 64'(ovf4), 64'h1);
      @(negedge clk);
      req4 = 16'h0004;
      #2 check("t6_grant", 64'(grant4), 64'h0004);
      @(negedge clk);
      req4 = 16'h0;
      #2 check("t6_aer_data_sat", 64'(bus4.aer_data), 64'h2F);
      @(negedge clk);
      en4 = 1'b0; clr4 = 1'b1;
      @(negedge clk);
      clr4 = 1'b0;
      #2;
      check("t6_ts_overflow_clr", 64'(ovf4), 64'h0);
      check("t6_aer_valid_clr", 64'(bus4.aer_valid), 64'h0);

      // all channels requesting: one grant per cycle in order
      do_reset();
      step(1, 0, 1, 16'hFFFF);
      repeat (16) step(1, 0, 1, 16'h0);

      // back-pressure holds the event and blocks grants
      step(1, 0, 0, 16'h0001);
      repeat (5) step(1, 0, 0, 16'h0080);
      if (exp_q.size() > 0) check("t4_hold_data", 64'(bus.aer_data), 64'(exp_q[0]));
      step(1, 0, 1, 16'h0);

      // clear_window discards the pending event and keeps the pointer
      step(1, 0, 0, 16'h0);
      step(1, 1, 0, 16'h0);
      step(1, 0, 1, 16'h0101);
      step(1, 0, 1, 16'h0);

      repeat (3000) rand_step();

      // reset in the middle of a burst
      step(1, 0, 0, 16'hFFFF);
      step(1, 0, 0, 16'h0);
      do_reset();
      repeat (300) rand_step();
      repeat (40) step(1, 0, 1, 16'h0);
      check("final_queue_empty", 64'(exp_q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
